fir4_inv_u: RTL and testbench

Inverse (deconvolving) stage for the 4-tap signed averaging FIR (`fir4rca_u`). It sits at the far end of the FIR's sum stream. It takes each `w+2`-bit tap sum `s[n] = x[n]+x[n-1]+x[n-2]+x[n-3]` and recursively reconstructs the original `w`-bit samples. Typical uses are closing the loop in self-checking benches and undoing the averaging in the datapath. Out-of-range reconstructions are saturated and flagged with a sticky error.

---
 rtl/fir4_inv_u.sv | 77 +++++++
 tb/tb_fir4_inv_u.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fir4_inv_u.sv
`default_nettype none
// ============================================================================
// Module   : fir4_inv_u
// Brief    : Recursive inverse of the 4-tap summing FIR. It rebuilds the w-bit
//            samples from the tap sums, with saturation and a sticky range flag.
// Revision : 1.0 - initial release
// ============================================================================
module fir4_inv_u #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W+1:0] s_in,
    input  logic                s_valid,
    input  logic                hist_clr,
    input  logic                err_clr,
    output logic signed [W-1:0] a_out,
    output logic                a_valid,
    output logic                range_err
);

    localparam logic signed [W+2:0] c_Y_MAX = {{4{1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [W+2:0] c_Y_MIN = {{4{1'b1}}, {(W-1){1'b0}}};

    logic signed [W-1:0] r_h1, r_h2, r_h3;
    logic signed [W+2:0] w_hsum;
    logic signed [W+2:0] w_d;
    logic signed [W-1:0] w_y;
    logic                w_sat;

    // w+3 bits holds s_in minus three full-scale samples without wrapping.
    always_comb begin
        w_hsum = (W+3)'(r_h1) + (W+3)'(r_h2) + (W+3)'(r_h3);
        w_d    = (W+3)'(s_in) - w_hsum;
        w_sat  = 1'b0;
        w_y    = w_d[W-1:0];
        if (w_d > c_Y_MAX) begin
            w_y   = c_Y_MAX[W-1:0];
            w_sat = 1'b1;
        end else if (w_d < c_Y_MIN) begin
            w_y   = c_Y_MIN[W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out     <= '0;
            a_valid   <= 1'b0;
            range_err <= 1'b0;
            r_h1      <= '0;
            r_h2      <= '0;
            r_h3      <= '0;
        end else begin
            a_valid <= s_valid;
            if (s_valid) begin
                a_out <= w_y;
                r_h1  <= w_y;
                r_h2  <= r_h1;
                r_h3  <= r_h2;
            end
            // Clearing the history overrides the shift of a concurrent sample.
            if (hist_clr) begin
                r_h1 <= '0;
                r_h2 <= '0;
                r_h3 <= '0;
            end
            if (s_valid && w_sat) begin
                range_err <= 1'b1;
            end else if (err_clr) begin
                range_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir4_inv_u.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir4_inv_u
// Brief    : Directed bench for fir4_inv_u with a behavioural FIR closed loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir4_inv_u;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [17:0] s_in;
    logic               s_valid;
    logic               hist_clr;
    logic               err_clr;
    logic signed [15:0] a_out;
    logic               a_valid;
    logic               range_err;

    int total = 0;
    int bad   = 0;

    fir4_inv_u dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .hist_clr  (hist_clr),
        .err_clr   (err_clr),
        .a_out     (a_out),
        .a_valid   (a_valid),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic signed [17:0] sv, input logic v,
                        input logic hc, input logic ec);
        @(negedge clk);
        s_in     = sv;
        s_valid  = v;
        hist_clr = hc;
        err_clr  = ec;
        @(posedge clk);
        #1;
    endtask

    logic signed [15:0] x0, x1, x2, x3;
    logic signed [17:0] fsum;
    int basic_s [5] = '{1, 3, 6, 10, 14};

    initial begin
        reset = 1'b1; s_in = '0; s_valid = 1'b0; hist_clr = 1'b0; err_clr = 1'b0;
        #2;
        chk("reset a_out", a_out, 0);
        chk("reset a_valid", a_valid, 0);
        chk("reset range_err", range_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic recovery
        for (int i = 0; i < 5; i++) begin
            step(18'(basic_s[i]), 1'b1, 1'b0, 1'b0);
            chk("basic a_out", a_out, i + 1);
            chk("basic a_valid", a_valid, 1);
        end
        chk("basic range_err", range_err, 0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("idle a_valid", a_valid, 0);
        chk("idle a_out hold", a_out, 5);

        // Negative and mixed signs
        step('0, 1'b0, 1'b1, 1'b0);
        step(-18'sd5, 1'b1, 1'b0, 1'b0);  chk("neg a0", a_out, -5);
        step(-18'sd5, 1'b1, 1'b0, 1'b0);  chk("neg a1", a_out, 0);
        step(18'sd95, 1'b1, 1'b0, 1'b0);  chk("neg a2", a_out, 100);
        step(18'sd95, 1'b1, 1'b0, 1'b0);  chk("neg a3", a_out, 0);

        // Gaps between valid samples
        step('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(18'(basic_s[i]), 1'b1, 1'b0, 1'b0);
            chk("gap a_out", a_out, i + 1);
            chk("gap a_valid", a_valid, 1);
            for (int g = 0; g < 3; g++) begin
                step(18'sd77, 1'b0, 1'b0, 1'b0);
                chk("gap idle a_valid", a_valid, 0);
                chk("gap idle a_out", a_out, i + 1);
            end
        end
        chk("gap range_err", range_err, 0);

        // Saturation from reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        step(18'sd40000, 1'b1, 1'b0, 1'b0);
        chk("sat hi a_out", a_out, 32767);
        chk("sat hi err", range_err, 1);
        step(-18'sd130000, 1'b1, 1'b0, 1'b0);
        chk("sat lo a_out", a_out, -32768);
        step(18'sd0, 1'b1, 1'b0, 1'b0);
        chk("post sat a_out", a_out, 1);
        chk("sticky err", range_err, 1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("err_clr", range_err, 0);
        // History 1,-32768,32767 sums to 0, so 40000 saturates again.
        step(18'sd40000, 1'b1, 1'b0, 1'b1);
        chk("set beats clr a_out", a_out, 32767);
        chk("set beats clr err", range_err, 1);

        // Random closed loop through a behavioural 4-tap FIR
        step('0, 1'b0, 1'b1, 1'b1);
        chk("loop start err", range_err, 0);
        x1 = '0; x2 = '0; x3 = '0;
        for (int i = 0; i < 30; i++) begin
            x0   = 16'($urandom_range(0, 65535));
            fsum = x0 + x1 + x2 + x3;
            step(fsum, 1'b1, 1'b0, 1'b0);
            chk("loop a_out", a_out, x0);
            x3 = x2; x2 = x1; x1 = x0;
        end
        chk("loop range_err", range_err, 0);

        // Asynchronous reset mid-stream
        step('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(18'(basic_s[i]), 1'b1, 1'b0, 1'b0);
        chk("pre-reset a_out", a_out, 4);
        @(negedge clk);
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async a_out", a_out, 0);
        chk("async a_valid", a_valid, 0);
        chk("async range_err", range_err, 0);
        @(negedge clk); reset = 1'b0;
        step(18'sd7, 1'b1, 1'b0, 1'b0);
        chk("after reset a_out", a_out, 7);

        // hist_clr together with a valid sample
        step(18'sd10, 1'b1, 1'b1, 1'b0);
        chk("clr+valid a_out", a_out, 3);
        step(18'sd4, 1'b1, 1'b0, 1'b0);
        chk("after clr a_out", a_out, 4);
        chk("after clr a_valid", a_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
